// File: rtl/serial_adder.sv
// Bit-serial adder: one gate-level full_adder cell walks over the operands
// LSB first, one bit pair per clock, with the carry held in a register
// between cycles. Operands arrive and the result leaves on valid/ready ports.

// One-bit full adder built from primitive gates.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  logic w_ab_x;

  assign w_ab_x = i_a ^ i_b;
  assign o_s    = w_ab_x ^ i_c;
  assign o_c    = (i_a & i_b) | (i_c & w_ab_x);

endmodule

// Handshake rules, both ports: a transfer happens on a rising edge where
// valid and ready are both high. in_ready is high in IDLE, and in DONE it
// follows out_ready, so a retiring result and a new operand pair can share
// one edge. out_valid is high only in DONE, and sum/cout hold still there
// until out_ready is seen. in_ready, out_valid and busy come from the state
// register (plus out_ready for in_ready), never from in_valid.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic             r_c_q;
  logic [CW-1:0]    r_cnt;
  logic             w_accept;
  logic             w_fa_s;
  logic             w_fa_c;
  logic [WIDTH-1:0] w_s_next;

  // The single bit slice: current LSBs plus the carry from the previous bit.
  full_adder u_fa (
    .i_a (r_a_sh[0]),
    .i_b (r_b_sh[0]),
    .i_c (r_c_q),
    .o_s (w_fa_s),
    .o_c (w_fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at bit 0.
  generate
    if (WIDTH == 1) begin : g_s_one
      assign w_s_next = w_fa_s;
    end else begin : g_s_many
      assign w_s_next = {w_fa_s, r_s_sh[WIDTH-1:1]};
    end
  endgenerate

  assign in_ready    = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign out_valid   = (r_state == S_DONE);
  assign busy        = (r_state == S_RUN);
  assign w_accept    = in_valid & in_ready;
  assign sum         = r_s_sh;
  assign cout        = r_c_q;
  assign o_dbg_state = r_state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; RUN lasts exactly WIDTH edges counted by r_cnt.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (in_valid) w_next_state = S_RUN;
      S_RUN:  if (r_cnt == LAST) w_next_state = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          w_next_state = in_valid ? S_RUN : S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: load on acceptance, shift one bit per RUN edge, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_s_sh <= '0;
      r_c_q  <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_a_sh <= a;
      r_b_sh <= b;
      r_c_q  <= cin;
      r_cnt  <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sh <= r_a_sh >> 1;
      r_b_sh <= r_b_sh >> 1;
      r_s_sh <= w_s_next;
      r_c_q  <= w_fa_c;
      r_cnt  <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): a driver issues operand pairs,
// pushing the hand-computed {cout,sum} into exp_q on acceptance; a monitor
// pops and compares every retired result.
module tb_serial_adder;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  serial_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
    .cout        (cout),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every transfer on the output port is checked against exp_q.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [W:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL result: unexpected result cout=%0b sum=%02h at %0t", cout, sum, $time);
      end else begin
        e = exp_q.pop_front();
        if ({cout, sum} !== e) begin
          failures++;
          $display("FAIL result: got cout=%0b sum=%02h expected cout=%0b sum=%02h at %0t",
                   cout, sum, e[W], e[W-1:0], $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present operands until accepted; returns at (acceptance edge + 1).
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input bit push, input logic [W:0] exp);
    int n;
    in_valid = 1'b1;
    a = ta;
    b = tb;
    cin = tc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
    end
    @(posedge clk);
    if (push && in_ready) exp_q.push_back(exp);
    #1;
    in_valid = 1'b0;
    a = W'($urandom_range(0, 255));
    b = W'($urandom_range(0, 255));
    cin = 1'($urandom_range(0, 1));
  endtask

  // Wait (bounded) for out_valid; nbusy = negedges seen with busy=1.
  task automatic wait_result(output int nbusy);
    int n;
    nbusy = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) nbusy++;
    end while (!out_valid && n < 50);
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL result_timeout: out_valid stayed 0, expected 1");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nb;

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      a   = W'($urandom_range(0, 255));
      b   = W'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sum_cout", 32'({cout, sum}), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    idle(1);

    // Basic add with latency check.
    send(8'h3C, 8'h45, 1'b0, 1'b1, 9'h081);
    wait_result(nb);
    chk("basic_latency", 32'(nb), 32'd8);
    idle(2);

    // Carry cases.
    send(8'hFF, 8'hFF, 1'b1, 1'b1, 9'h1FF);
    wait_result(nb);
    idle(2);
    send(8'h00, 8'h00, 1'b1, 1'b1, 9'h001);
    wait_result(nb);
    idle(2);
    send(8'h80, 8'h80, 1'b0, 1'b1, 9'h100);
    wait_result(nb);
    idle(2);

    // Backpressure: hold result 5 cycles while in_valid and operands wiggle.
    out_ready = 1'b0;
    send(8'hA5, 8'h5A, 1'b0, 1'b1, 9'h0FF);
    wait_result(nb);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i % 2 == 0);
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_hold", 32'({cout, sum}), 32'h0FF);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_retired_out_valid", 32'(out_valid), 32'd0);
    chk("bp_no_capture_busy", 32'(busy), 32'd0);
    idle(1);

    // Back-to-back: retire and accept on the same edge.
    out_ready = 1'b0;
    send(8'hFF, 8'h01, 1'b0, 1'b1, 9'h100);
    wait_result(nb);
    chk("b2b_in_ready_blocked", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(8'h10, 8'h20, 1'b0, 1'b1, 9'h030);
    wait_result(nb);
    chk("b2b_latency", 32'(nb), 32'd8);
    idle(2);

    // Reset after the 3rd RUN edge aborts the operation.
    send(8'h7F, 8'h01, 1'b0, 1'b0, 9'h000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum_cout", 32'({cout, sum}), 32'd0);
    idle(2);
    rst_n = 1'b1;
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) nb++;
    end
    chk("midrst_no_result", 32'(nb), 32'd0);
    idle(1);
    send(8'h7F, 8'h01, 1'b0, 1'b1, 9'h080);
    wait_result(nb);
    chk("rerun_latency", 32'(nb), 32'd8);
    idle(3);

    // Final report.
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
